// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target byte engine with oversampled pins and a one-byte transmit holding buffer
module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] txdata,
    input  logic       txload,
    output logic       txready,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    output logic       selected,
    output logic       tx_underrun
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    // A selection needs cs_n seen high for this many consecutive cycles, so the
    // idle level forced into the synchronizer by reset cannot fake a falling edge.
    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_hist_q, cs_hist_q;
    logic [2:0]             cs_hi_q, cs_hi_d;
    state_t                 state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic                   bnd_q, bnd_d;
    logic [7:0]             txshift_q, txshift_d;
    logic [7:0]             rxshift_q, rxshift_d;
    logic [7:0]             rxdata_q, rxdata_d;
    logic [7:0]             buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   rxvalid_q, rxvalid_d;
    logic                   underrun_q, underrun_d;

    logic sck_s, cs_s, mosi_s;
    logic enter, leave, act, sck_rise, sck_fall, load;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign enter    = (state_q == IDLE) && (state_d == ACTIVE);
    assign leave    = (state_q == ACTIVE) && cs_s;
    assign act      = (state_q == ACTIVE) && !cs_s;
    assign sck_rise = act && sck_s && !sck_hist_q;
    assign sck_fall = act && !sck_s && sck_hist_q;
    assign load     = enter || (sck_fall && bnd_q);
    assign cs_hi_d  = cs_s ? ((cs_hi_q == ARM_CNT) ? cs_hi_q : cs_hi_q + 3'd1) : 3'd0;

    // Pin synchronizers, edge-detect history and the cs_n-high arming counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            cs_hist_q   <= 1'b1;
            cs_hi_q     <= 3'd0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_hist_q  <= sck_s;
            cs_hist_q   <= cs_s;
            cs_hi_q     <= cs_hi_d;
        end
    end

    // Selection state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Select on an armed synchronized cs_n fall, deselect as soon as cs_n reads high
    always_comb begin
        state_d = (state_q == IDLE) ? ((!cs_s && cs_hi_q == ARM_CNT) ? ACTIVE : IDLE)
                                    : (cs_s ? IDLE : ACTIVE);
    end

    // Pin and status outputs derived from state and registers
    always_comb begin
        selected    = (state_q == ACTIVE);
        spi_miso_oe = (state_q == ACTIVE);
        spi_miso    = txshift_q[7];
        txready     = !buf_full_q;
        rxdata      = rxdata_q;
        rxvalid     = rxvalid_q;
        tx_underrun = underrun_q;
    end

    // Shift, bit-count, holding-buffer and byte-boundary next state
    always_comb begin
        bitcnt_d   = bitcnt_q;
        bnd_d      = bnd_q;
        txshift_d  = txshift_q;
        rxshift_d  = rxshift_q;
        rxdata_d   = rxdata_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rxvalid_d  = 1'b0;
        underrun_d = 1'b0;
        if (txload && !buf_full_q && !load) begin
            buf_d      = txdata;
            buf_full_d = 1'b1;
        end
        if (load) begin
            txshift_d  = buf_full_q ? buf_q : (txload ? txdata : 8'hFF);
            underrun_d = !buf_full_q && !txload;
            buf_full_d = 1'b0;
            bnd_d      = 1'b0;
            bitcnt_d   = 3'd0;
        end else if (sck_fall && bitcnt_q != 3'd0) begin
            txshift_d = {txshift_q[6:0], 1'b1};
        end
        if (sck_rise) begin
            rxshift_d = {rxshift_q[6:0], mosi_s};
            bitcnt_d  = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                rxdata_d  = {rxshift_q[6:0], mosi_s};
                rxvalid_d = 1'b1;
                bnd_d     = 1'b1;
            end
        end
        if (leave) begin
            bitcnt_d  = 3'd0;
            bnd_d     = 1'b0;
            txshift_d = 8'hFF;
            rxshift_d = 8'h00;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt_q   <= 3'd0;
            bnd_q      <= 1'b0;
            txshift_q  <= 8'hFF;
            rxshift_q  <= 8'h00;
            rxdata_q   <= 8'h00;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            rxvalid_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            bnd_q      <= bnd_d;
            txshift_q  <= txshift_d;
            rxshift_q  <= rxshift_d;
            rxdata_q   <= rxdata_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rxvalid_q  <= rxvalid_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed mode-0 host transfers against spi_target
`timescale 1ns/1ps
module tb_spi_target;
    logic       clk = 1'b0;
    logic       rst, spi_sck, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] txdata;
    logic       txload;
    logic       txready;
    logic [7:0] rxdata;
    logic       rxvalid, selected, tx_underrun;

    int tests = 0;
    int fails = 0;
    int urun_cnt = 0;
    int rxv_cnt = 0;

    spi_target dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .txdata(txdata), .txload(txload),
        .txready(txready), .rxdata(rxdata), .rxvalid(rxvalid), .selected(selected),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_underrun === 1'b1) urun_cnt <= urun_cnt + 1;
        if (rxvalid === 1'b1) rxv_cnt <= rxv_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load_tx(input logic [7:0] d);
        txdata = d;
        txload = 1'b1;
        tick();
        txload = 1'b0;
    endtask

    // Host side: SCK = clk/16, MISO sampled at each SCK rise, ends right after driving the last fall
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi, output int vpos);
        mi = 8'hFF;
        vpos = 0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            ticks(8);
            mi = {mi[6:0], spi_miso};
            spi_sck = 1'b1;
            for (int j = 1; j <= 8; j++) begin
                tick();
                if (rxvalid === 1'b1 && vpos == 0) vpos = j;
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, spi_miso, 1);
        chk({tag, "_oe"}, spi_miso_oe, 0);
        chk({tag, "_txready"}, txready, 1);
        chk({tag, "_rxdata"}, rxdata, 0);
        chk({tag, "_rxvalid"}, rxvalid, 0);
        chk({tag, "_selected"}, selected, 0);
        chk({tag, "_underrun"}, tx_underrun, 0);
    endtask

    initial begin
        logic [7:0] mi, mi1, mi2, mi3;
        int vp, u0, v0;
        rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; txdata = 8'h00; txload = 1'b0;
        ticks(3);
        chk_reset("reset");
        rst = 1'b0;
        ticks(8);

        load_tx(8'hA5);
        chk("t1_txready_full", txready, 0);
        v0 = rxv_cnt;
        spi_cs_n = 1'b0;
        ticks(8);
        chk("t1_selected", selected, 1);
        chk("t1_oe", spi_miso_oe, 1);
        chk("t1_txready_after_cs", txready, 1);
        xfer(8'h3C, 8, mi, vp);
        chk("t1_miso", mi, 8'hA5);
        chk("t1_rxvalid_edge", vp, 3);
        ticks(8);
        chk("t1_rxdata", rxdata, 8'h3C);
        chk("t1_rxvalid_count", rxv_cnt - v0, 1);
        spi_cs_n = 1'b1;
        ticks(8);
        chk("t1_deselected", selected, 0);
        chk("t1_oe_off", spi_miso_oe, 0);

        u0 = urun_cnt; v0 = rxv_cnt;
        spi_cs_n = 1'b0;
        ticks(8);
        chk("t2_underrun_at_select", urun_cnt - u0, 1);
        xfer(8'h00, 8, mi, vp);
        chk("t2_miso", mi, 8'hFF);
        chk("t2_underrun_once", urun_cnt - u0, 1);
        chk("t2_rxdata", rxdata, 8'h00);
        chk("t2_rxvalid_count", rxv_cnt - v0, 1);
        ticks(8);
        spi_cs_n = 1'b1;
        ticks(8);

        load_tx(8'h11);
        u0 = urun_cnt; v0 = rxv_cnt;
        spi_cs_n = 1'b0;
        ticks(8);
        load_tx(8'h22);
        xfer(8'hDE, 8, mi1, vp);
        chk("t3_rxdata0", rxdata, 8'hDE);
        ticks(4);
        load_tx(8'h33);
        xfer(8'hAD, 8, mi2, vp);
        chk("t3_rxdata1", rxdata, 8'hAD);
        ticks(4);
        xfer(8'hBE, 8, mi3, vp);
        chk("t3_rxdata2", rxdata, 8'hBE);
        chk("t3_miso0", mi1, 8'h11);
        chk("t3_miso1", mi2, 8'h22);
        chk("t3_miso2", mi3, 8'h33);
        chk("t3_no_underrun", urun_cnt - u0, 0);
        chk("t3_rxvalid_count", rxv_cnt - v0, 3);
        ticks(8);
        spi_cs_n = 1'b1;
        ticks(8);

        load_tx(8'hC3);
        v0 = rxv_cnt;
        spi_cs_n = 1'b0;
        ticks(8);
        load_tx(8'h96);
        xfer(8'hF0, 5, mi, vp);
        chk("t4_partial_miso", mi, 8'hF8);
        ticks(8);
        spi_cs_n = 1'b1;
        ticks(8);
        chk("t4_rxdata_kept", rxdata, 8'hBE);
        chk("t4_no_rxvalid", rxv_cnt - v0, 0);
        chk("t4_buffer_kept", txready, 0);
        v0 = rxv_cnt;
        spi_cs_n = 1'b0;
        ticks(8);
        chk("t4_txready_reselect", txready, 1);
        xfer(8'h81, 8, mi, vp);
        chk("t4_miso_restart", mi, 8'h96);
        chk("t4_rxdata", rxdata, 8'h81);
        chk("t4_rxvalid_count", rxv_cnt - v0, 1);
        ticks(8);
        spi_cs_n = 1'b1;
        ticks(8);

        load_tx(8'h77);
        spi_cs_n = 1'b0;
        ticks(8);
        xfer(8'h12, 8, mi, vp);
        chk("t5_miso0", mi, 8'h77);
        u0 = urun_cnt;
        tick();
        tick();
        txdata = 8'h5A;
        txload = 1'b1;
        tick();
        txload = 1'b0;
        chk("t5_txready", txready, 1);
        chk("t5_underrun", tx_underrun, 0);
        chk("t5_miso_msb", spi_miso, 0);
        xfer(8'h34, 8, mi, vp);
        chk("t5_miso1", mi, 8'h5A);
        chk("t5_rxdata", rxdata, 8'h34);
        chk("t5_no_underrun", urun_cnt - u0, 0);
        ticks(8);
        spi_cs_n = 1'b1;
        ticks(8);

        load_tx(8'hE7);
        spi_cs_n = 1'b0;
        ticks(8);
        xfer(8'hF0, 4, mi, vp);
        spi_mosi = 1'b1;
        ticks(8);
        spi_sck = 1'b1;
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6_reset");
        v0 = rxv_cnt;
        ticks(6);
        spi_sck = 1'b0;
        xfer(8'hFF, 3, mi, vp);
        ticks(8);
        chk("t6_ignored_selected", selected, 0);
        chk("t6_ignored_oe", spi_miso_oe, 0);
        chk("t6_ignored_rxvalid", rxv_cnt - v0, 0);
        chk("t6_ignored_rxdata", rxdata, 8'h00);
        spi_cs_n = 1'b1;
        ticks(8);
        spi_cs_n = 1'b0;
        ticks(8);
        chk("t6_reselected", selected, 1);
        xfer(8'h5C, 8, mi, vp);
        chk("t6_rxdata", rxdata, 8'h5C);
        chk("t6_miso_empty", mi, 8'hFF);
        ticks(8);
        spi_cs_n = 1'b1;
        ticks(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
SPI peripheral-side (target) byte engine. It is the counterpart to the team's SPI host controller: SPI mode 0, 8-bit frames, MSB first, full duplex.
- Oversamples the external SCK, CS_n and MOSI on the system clock.
- Shifts received bytes out to a register interface.
- Drives MISO from a one-byte transmit holding buffer.
- Used to let an external host (debug MCU, test fixture) read and write Vera registers over SPI.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on spi_sck, spi_cs_n and spi_mosi (legal range 2..3).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
spi_sck  input  1  SPI clock from external host, asynchronous to clk
spi_cs_n  input  1  chip select, active low, asynchronous
spi_mosi  input  1  host-to-target data
spi_miso  output  1  target-to-host data
spi_miso_oe  output  1  MISO output enable, high while selected
txdata  input  8  next byte to transmit
txload  input  1  write txdata into the holding buffer
txready  output  1  holding buffer empty, txload accepted
rxdata  output  8  last complete received byte, held until the next one completes
rxvalid  output  1  one-cycle pulse: rxdata updated
selected  output  1  synchronized chip-select active
tx_underrun  output  1  one-cycle pulse: a byte boundary found the holding buffer empty

Behaviour:
- Reset (rst high at a clk edge) forces: spi_miso=1, spi_miso_oe=0, txready=1, rxdata=0x00, rxvalid=0, selected=0, tx_underrun=0. The holding buffer is cleared, bit counter=0, shift registers=0xFF (tx) / 0x00 (rx), and the synchronizer chains are loaded with idle levels (sck=0, cs_n=1, mosi=0). Reset mid-transfer abandons the byte silently.
- Synchronization:
  - Each of sck, cs_n and mosi passes through SYNC_STAGES flops, plus one history flop on sck and cs_n for edge detection.
  - A synchronized edge is acted on in the cycle it is detected, so registered results appear on the (SYNC_STAGES+1)th clk rising edge after the pin change.
  - mosi uses the same depth, so it is sampled coherently with sck.
- Timing constraint on the host: SCK high and low phases each ≥ SYNC_STAGES+2 clk periods. CS_n falling to first SCK rise ≥ SYNC_STAGES+2 clk periods.
- States:
  - IDLE: cs_n synced high. SCK edges are ignored.
  - ACTIVE: entered on synced cs_n fall, left on synced cs_n rise.
  - selected=1 and spi_miso_oe=1 exactly while ACTIVE.
- Entering ACTIVE:
  - bitcnt=0.
  - TX shift register loads from the holding buffer if full (txready goes 1), else loads 0xFF and pulses tx_underrun.
  - spi_miso = txshift[7] throughout.
- Synced SCK rising edge in ACTIVE:
  - rxshift <= {rxshift[6:0], mosi_sync}; bitcnt++.
  - When bitcnt was 7: rxdata <= {rxshift[6:0], mosi_sync}, rxvalid pulses 1 cycle, bitcnt <= 0, boundary_pending <= 1.
- Synced SCK falling edge in ACTIVE:
  - If boundary_pending: load the next byte into txshift (same rule as CS assertion: holding buffer or 0xFF with tx_underrun) and clear boundary_pending.
  - Else if bitcnt≠0: txshift <= {txshift[6:0],1'b1}.
  - A falling edge before the first rising edge of a frame does not shift.
- Holding buffer:
  - txload while txready=1 captures txdata; txready drops next cycle.
  - txload while txready=0 is ignored (no overwrite).
- Simultaneous txload with a load event (CS assertion or boundary) while the buffer is empty: txdata goes directly into txshift, no tx_underrun, buffer stays empty, txready stays 1.
- CS_n rising mid-byte:
  - Partial rx bits are discarded, no rxvalid, bitcnt=0, boundary_pending=0.
  - A partially sent tx byte is lost.
  - The holding buffer content is preserved for the next selection.
- rxdata is never cleared except by reset. rxvalid is never asserted while IDLE.

Test Plan:
1. Load 0xA5, assert CS, host clocks 0x3C at SCK=clk/16 → MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; one rxvalid pulse on the 3rd clk edge after the 8th SCK rise; txready=1 after CS assertion.
2. No txload, assert CS, 8 clocks of 0x00 → tx_underrun pulses once at selection; MISO all 1s (0xFF); rxdata=0x00 with rxvalid.
3. Back-to-back 3-byte frame, txload 0x11/0x22/0x33 each time txready rises; host sends 0xDE,0xAD,0xBE → MISO 0x11,0x22,0x33 with no underrun; rxvalid ×3 with the matching rxdata.
4. CS_n deasserted after 5 SCK rises mid-byte → no rxvalid, rxdata unchanged. Next frame 0x81 received correctly and MISO restarts from the holding byte.
5. txload 0x5A asserted in the exact cycle of the boundary load with the buffer empty → MISO sends 0x5A, tx_underrun stays 0, txready stays 1.
6. rst pulsed during bit 4 of a transfer → all outputs take their reset values after that clk edge. The remaining SCK edges in that selection are ignored until CS_n goes high and low again.
